// File: rtl/cs_pkg.sv
// cs_pkg: shared constants, symbol/erasure types and scheduler states for the (2,3) cyclic-shift MDS codec
package cs_pkg;
    localparam int CS_WIDTH = 4;
    localparam int CS_N     = 3;
    localparam int CS_K     = 2;
    typedef logic [CS_WIDTH-1:0] cs_sym_t;
    typedef logic [CS_N-1:0] cs_erasure_t;
    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT, OUTPUT} cs_sched_state_t;
endpackage

// File: rtl/cs_gen_timer.sv
// cs_gen_timer: generation timeout counter with clear, enable and expire
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count (wins over en)
//   en         : count this cycle
//   expire     : count has reached TIMEOUT_CYC-1 while enabled
module cs_gen_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
    assign expire = en && (cnt == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/cs_gen_scheduler.sv
// cs_gen_scheduler: collects one generation of coded symbols, issues a decode request and buffers the result
//   sym_*       : indexed symbol stream in (idx 0=d0, 1=d1, 2=p0, 3=illegal), ready only while collecting
//   dec_*       : decode request out (1-cycle pulse, erasure mask, slots) and registered decoder result in
//   out_*       : valid/ready result {d1,d0} with decode_ok
//   gen_cnt, fail_cnt, drop_cnt : completed generations, failed generations, dropped symbols (saturating)
module cs_gen_scheduler
    import cs_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sym_valid,
    output logic                      sym_ready,
    input  logic [1:0]                sym_idx,
    input  logic [CS_WIDTH-1:0]       sym_data,
    input  logic                      sym_last,
    output logic                      dec_valid_in,
    output logic [CS_N-1:0]           dec_erasure,
    output logic [CS_N*CS_WIDTH-1:0]  dec_coded,
    input  logic                      dec_valid_out,
    input  logic                      dec_decode_ok,
    input  logic [CS_K*CS_WIDTH-1:0]  dec_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_ok,
    output logic [CS_K*CS_WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]          gen_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic [7:0]                drop_cnt
);
    cs_sched_state_t state, state_nxt;
    cs_erasure_t rcv, rcv_nxt;
    logic [CS_N-1:0][CS_WIDTH-1:0] slots, slots_nxt;
    logic [3:0] filled;
    logic accept, fresh, drop, close, hs, timer_expire;

    // index 3 is treated as a permanently filled slot so it always drops
    assign filled = {1'b1, rcv};
    assign accept = sym_valid && sym_ready;
    assign fresh  = accept && !filled[sym_idx];
    assign drop   = accept && filled[sym_idx];
    assign hs     = out_valid && out_ready;
    // the closing symbol is folded in via rcv_nxt/slots_nxt, so a same-cycle timeout still keeps it
    assign close  = (accept && sym_last && |rcv_nxt) || (state == COLLECT && &rcv_nxt) || timer_expire;

    always_comb begin
        rcv_nxt   = rcv;
        slots_nxt = slots;
        for (int i = 0; i < CS_N; i++) begin
            rcv_nxt[i]   = rcv[i] | (fresh && sym_idx == 2'(i));
            slots_nxt[i] = (fresh && sym_idx == 2'(i)) ? sym_data : slots[i];
        end
    end

    cs_gen_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (close || hs),
        .en     (state == COLLECT && |rcv),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sym_ready    = 1'b0;
        dec_valid_in = 1'b0;
        out_valid    = 1'b0;
        case (state)
            COLLECT: begin
                sym_ready = 1'b1;
                if (close) state_nxt = ISSUE;
            end
            ISSUE: begin
                dec_valid_in = 1'b1;
                state_nxt    = WAIT;
            end
            WAIT:    if (dec_valid_out) state_nxt = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcv         <= '0;
            slots       <= '0;
            dec_erasure <= '0;
            dec_coded   <= '0;
            out_ok      <= 1'b0;
            out_data    <= '0;
            gen_cnt     <= '0;
            fail_cnt    <= '0;
            drop_cnt    <= '0;
        end else begin
            if (hs) begin
                rcv      <= '0;
                slots    <= '0;
                gen_cnt  <= gen_cnt + 1'b1;
                fail_cnt <= fail_cnt + CNT_W'(!out_ok);
            end else begin
                rcv   <= rcv_nxt;
                slots <= slots_nxt;
            end
            // request fields are loaded at close so they are valid during ISSUE and held afterwards
            if (close) begin
                dec_erasure <= ~rcv_nxt;
                dec_coded   <= slots_nxt;
            end
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (state == WAIT && dec_valid_out) begin
                out_ok   <= dec_decode_ok;
                out_data <= dec_data;
            end
        end
    end
endmodule

// File: tb/tb_cs_gen_scheduler.sv
// tb_cs_gen_scheduler: randomized self-checking bench for cs_gen_scheduler with a behavioural decoder
module tb_cs_gen_scheduler;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] data;
        logic       last;
        int         gap;
    } sym_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [1:0]  sym_idx = '0;
    logic [3:0]  sym_data = '0;
    logic        sym_last = 1'b0;
    logic        dec_valid_in;
    logic [2:0]  dec_erasure;
    logic [11:0] dec_coded;
    logic        dec_valid_out;
    logic        dec_decode_ok;
    logic [7:0]  dec_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_ok;
    logic [7:0]  out_data;
    logic [15:0] gen_cnt, fail_cnt;
    logic [7:0]  drop_cnt;

    int errors = 0, checks = 0;
    int exp_gen = 0, exp_fail = 0, exp_drop = 0;
    int issue_n = 0;
    logic [2:0]  cap_er = '0;
    logic [11:0] cap_co = '0;
    sym_t sym_q[$];

    cs_gen_scheduler #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_idx(sym_idx), .sym_data(sym_data), .sym_last(sym_last),
        .dec_valid_in(dec_valid_in), .dec_erasure(dec_erasure), .dec_coded(dec_coded),
        .dec_valid_out(dec_valid_out), .dec_decode_ok(dec_decode_ok), .dec_data(dec_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ok(out_ok), .out_data(out_data),
        .gen_cnt(gen_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rotr(input logic [3:0] v, input int n);
        return (v >> n) | (v << (4 - n));
    endfunction

    function automatic logic [3:0] parity(input logic [3:0] d0, input logic [3:0] d1);
        return rotr(d0, 1) ^ rotr(d1, 2);
    endfunction

    // erasure decoder: recovers a single erased data symbol from the parity; two erasures fail
    function automatic logic [8:0] decode(input logic [2:0] er, input logic [11:0] co);
        logic [3:0] c0, c1, p;
        c0 = co[3:0];
        c1 = co[7:4];
        p  = co[11:8];
        case (er)
            3'b000, 3'b100: return {1'b1, c1, c0};
            3'b001:         return {1'b1, c1, rotr(p ^ rotr(c1, 2), 3)};
            3'b010:         return {1'b1, rotr(p ^ rotr(c0, 1), 2), c0};
            default:        return 9'h000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_out <= 1'b0;
            dec_decode_ok <= 1'b0;
            dec_data      <= '0;
        end else begin
            dec_valid_out <= dec_valid_in;
            if (dec_valid_in)
                {dec_decode_ok, dec_data} <= decode(dec_erasure, dec_coded);
        end
    end

    always @(posedge clk) begin
        if (dec_valid_in === 1'b1) begin
            issue_n <= issue_n + 1;
            cap_er  <= dec_erasure;
            cap_co  <= dec_coded;
        end
    end

    // Plays sym_q as one generation. The model works out which symbols are stored, dropped or
    // never sent (generation already closed), the close edge (symbol close or first store + TIMEOUT),
    // and the result. Edges are counted from task entry; out_valid shows in the third cycle after the
    // closing cycle, i.e. right after edge close_e+2.
    task automatic run_gen(input logic [3:0] d0, input logic [3:0] d1, input int hold, input string tag);
        logic [2:0]  rcv, er;
        logic [11:0] co;
        logic        ok;
        logic [7:0]  exp_data;
        int drops, n_send, first_e, close_e, e, ix, start_issue;
        rcv = '0; co = '0; drops = 0; n_send = 0; first_e = -1; close_e = -1; e = 0;
        foreach (sym_q[k]) begin
            e += sym_q[k].gap + 1;
            if (first_e >= 0 && e > first_e + TIMEOUT) break;
            n_send++;
            ix = int'(sym_q[k].idx);
            if (ix == 3) drops++;
            else if (rcv[ix]) drops++;
            else begin
                rcv[ix] = 1'b1;
                co[ix*4 +: 4] = sym_q[k].data;
                if (first_e < 0) first_e = e;
            end
            if ((sym_q[k].last && rcv != 0) || rcv == 3'b111 || (first_e >= 0 && e == first_e + TIMEOUT)) begin
                close_e = e;
                break;
            end
        end
        if (close_e < 0) close_e = first_e + TIMEOUT;
        er = ~rcv;
        ok = $countones(er) <= 1;
        exp_data = ok ? {d1, d0} : 8'h00;

        start_issue = issue_n;
        e = 0;
        for (int k = 0; k < n_send; k++) begin
            repeat (sym_q[k].gap) begin @(posedge clk); e++; #1; end
            sym_valid = 1'b1; sym_idx = sym_q[k].idx; sym_data = sym_q[k].data; sym_last = sym_q[k].last;
            checks++;
            if (sym_ready !== 1'b1) begin errors++; $display("FAIL %s sym_ready sym%0d: got %b want 1", tag, k, sym_ready); end
            @(posedge clk); e++; #1;
            sym_valid = 1'b0; sym_last = 1'b0;
        end
        while (out_valid !== 1'b1 && e < close_e + 10) begin @(posedge clk); e++; #1; end
        checks++;
        if (out_valid !== 1'b1 || e != close_e + 2) begin
            errors++; $display("FAIL %s latency: out_valid=%b at edge %0d want 1 at edge %0d", tag, out_valid, e, close_e + 2);
        end
        checks++;
        if (issue_n - start_issue != 1) begin errors++; $display("FAIL %s issue pulses: got %0d want 1", tag, issue_n - start_issue); end
        checks++;
        if (cap_er !== er || cap_co !== co) begin
            errors++; $display("FAIL %s request: erasure=%b coded=%h want %b %h", tag, cap_er, cap_co, er, co);
        end
        checks++;
        if (dec_erasure !== er || dec_coded !== co || dec_valid_in !== 1'b0) begin
            errors++; $display("FAIL %s held request: erasure=%b coded=%h vin=%b want %b %h 0", tag, dec_erasure, dec_coded, dec_valid_in, er, co);
        end
        checks++;
        if (out_ok !== ok || out_data !== exp_data) begin
            errors++; $display("FAIL %s result: ok=%b data=%h want %b %h", tag, out_ok, out_data, ok, exp_data);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_ok !== ok || out_data !== exp_data || sym_ready !== 1'b0 || gen_cnt !== 16'(exp_gen)) begin
                errors++; $display("FAIL %s hold%0d: valid=%b ok=%b data=%h ready=%b gen=%0d want 1 %b %h 0 %0d",
                                   tag, h, out_valid, out_ok, out_data, sym_ready, gen_cnt, ok, exp_data, exp_gen);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_gen++;
        if (!ok) exp_fail++;
        exp_drop = (exp_drop + drops > 255) ? 255 : exp_drop + drops;
        checks++;
        if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin
            errors++; $display("FAIL %s after handshake: out_valid=%b sym_ready=%b want 0 1", tag, out_valid, sym_ready);
        end
        checks++;
        if (gen_cnt !== 16'(exp_gen) || fail_cnt !== 16'(exp_fail) || drop_cnt !== 8'(exp_drop)) begin
            errors++; $display("FAIL %s counters: gen=%0d fail=%0d drop=%0d want %0d %0d %0d",
                               tag, gen_cnt, fail_cnt, drop_cnt, exp_gen, exp_fail, exp_drop);
        end
    endtask

    task automatic load_full;
        sym_q.delete();
        sym_q.push_back('{2'd0, 4'h3, 1'b0, 0});
        sym_q.push_back('{2'd1, 4'h5, 1'b0, 0});
        sym_q.push_back('{2'd2, 4'hC, 1'b0, 0});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sym_ready !== 1'b1 || out_valid !== 1'b0 || dec_valid_in !== 1'b0) begin
            errors++; $display("FAIL reset handshakes: sym_ready=%b out_valid=%b dec_valid_in=%b want 1 0 0", sym_ready, out_valid, dec_valid_in);
        end
        checks++;
        if (dec_erasure !== 3'b000 || dec_coded !== 12'h000 || out_ok !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset data: erasure=%b coded=%h ok=%b data=%h want all 0", dec_erasure, dec_coded, out_ok, out_data);
        end
        checks++;
        if (gen_cnt !== 16'h0 || fail_cnt !== 16'h0 || drop_cnt !== 8'h0) begin
            errors++; $display("FAIL reset counters: gen=%0d fail=%0d drop=%0d want 0", gen_cnt, fail_cnt, drop_cnt);
        end
    endtask

    task automatic test_full_gen;
        load_full();
        run_gen(4'h3, 4'h5, 0, "full");
    endtask

    task automatic test_last_close;
        sym_q.delete();
        sym_q.push_back('{2'd1, 4'h5, 1'b0, 0});
        sym_q.push_back('{2'd2, 4'hC, 1'b1, 0});
        run_gen(4'h3, 4'h5, 0, "last");
    endtask

    task automatic test_timeout;
        sym_q.delete();
        sym_q.push_back('{2'd0, 4'h3, 1'b0, 0});
        run_gen(4'h3, 4'h5, 0, "timeout");
        sym_q.delete();
        sym_q.push_back('{2'd0, 4'h3, 1'b0, 0});
        sym_q.push_back('{2'd1, 4'h5, 1'b0, TIMEOUT - 1});
        run_gen(4'h3, 4'h5, 0, "timeout_same_cycle");
        sym_q.delete();
        sym_q.push_back('{2'd0, 4'h3, 1'b0, 0});
        sym_q.push_back('{2'd1, 4'h5, 1'b0, TIMEOUT - 2});
        run_gen(4'h3, 4'h5, 0, "timeout_one_before");
    endtask

    task automatic test_drops;
        sym_q.delete();
        sym_q.push_back('{2'd0, 4'h3, 1'b0, 0});
        sym_q.push_back('{2'd0, 4'h7, 1'b0, 0});
        sym_q.push_back('{2'd3, 4'hF, 1'b0, 0});
        sym_q.push_back('{2'd2, 4'hC, 1'b1, 0});
        run_gen(4'h3, 4'h5, 0, "drops");
    endtask

    task automatic test_backpressure;
        load_full();
        run_gen(4'h3, 4'h5, 10, "backpressure");
    endtask

    task automatic test_reset_mid;
        int s, n;
        s = issue_n;
        for (int k = 0; k < 3; k++) begin
            sym_valid = 1'b1; sym_idx = 2'(k); sym_data = (k == 0) ? 4'h3 : (k == 1) ? 4'h5 : 4'hC; sym_last = 1'b0;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0;
        n = 0;
        while (issue_n == s && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (issue_n != s + 1) begin errors++; $display("FAIL reset_mid issue: got %0d pulses want 1", issue_n - s); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dec_valid_in !== 1'b0 || dec_erasure !== 3'b000 || dec_coded !== 12'h000 ||
            out_ok !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL reset_mid outputs: valid=%b vin=%b er=%b co=%h ok=%b data=%h want all 0",
                               out_valid, dec_valid_in, dec_erasure, dec_coded, out_ok, out_data);
        end
        checks++;
        if (gen_cnt !== 16'h0 || fail_cnt !== 16'h0 || drop_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_mid counters: gen=%0d fail=%0d drop=%0d want 0", gen_cnt, fail_cnt, drop_cnt);
        end
        exp_gen = 0; exp_fail = 0; exp_drop = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_full();
        run_gen(4'h3, 4'h5, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [3:0] d0, d1, data;
        logic [3:0] vals [3];
        logic [2:0] seen;
        logic [1:0] idx;
        int n;
        for (int g = 0; g < 40; g++) begin
            d0 = 4'($urandom); d1 = 4'($urandom);
            vals[0] = d0; vals[1] = d1; vals[2] = parity(d0, d1);
            seen = '0;
            sym_q.delete();
            n = $urandom_range(1, 5);
            for (int j = 0; j < n; j++) begin
                idx = 2'($urandom_range(0, 3));
                if (idx == 2'd3) data = 4'($urandom);
                else if (seen[idx]) data = 4'($urandom);
                else begin data = vals[idx]; seen[idx] = 1'b1; end
                sym_q.push_back('{idx, data, (j == n - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0), $urandom_range(0, 2)});
            end
            if (seen == 3'b000) sym_q.push_back('{2'd0, d0, 1'b1, 0});
            run_gen(d0, d1, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_drop_saturate;
        int s;
        s = issue_n;
        for (int k = 0; k < 300; k++) begin
            sym_valid = 1'b1; sym_idx = 2'd3; sym_data = 4'($urandom); sym_last = 1'b1;
            @(posedge clk); #1;
        end
        sym_valid = 1'b0; sym_last = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL drop_saturate: drop_cnt=%0d want 255", drop_cnt); end
        checks++;
        if (issue_n != s || sym_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL empty_last: issues=%0d sym_ready=%b out_valid=%b want 0 1 0", issue_n - s, sym_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_gen();
        test_last_close();
        test_timeout();
        test_drops();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_drop_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
